// File: rtl/pwm_capture.sv
// pwm_capture: measures period/high time of a sampled PWM line in prescaled ticks and classifies duty into levels 0..4
module pwm_capture #(
  parameter int DIV = 100,
  parameter int CNT_W = 10,
  parameter int TIMEOUT = 1000
)(
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_pwm,
  output logic [CNT_W-1:0] o_period,
  output logic [CNT_W-1:0] o_high,
  output logic [3:0]       o_level,
  output logic             o_valid,
  output logic             o_stuck
);
  typedef enum logic [1:0] {IDLE, MEASURE, STUCK} state_t;
  localparam int PW = $clog2(DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO = CNT_W'(TIMEOUT);
  state_t state;
  logic s1, s, prev, tick, rise;
  logic [PW-1:0] pre;
  logic [CNT_W-1:0] per_cnt, hi_cnt;
  logic [CNT_W+2:0] h8, p1, p3, p5, p7;
  logic [3:0] level;
  assign tick = pre == PRE_MAX;
  assign rise = s & ~prev;
  // duty rounded to nearest quarter: count thresholds 8H >= (2k-1)P, widened so nothing truncates
  always_comb begin
    p1 = {3'b0, per_cnt};
    p3 = (p1 << 1) + p1;
    p5 = (p1 << 2) + p1;
    p7 = (p1 << 3) - p1;
    h8 = {hi_cnt, 3'b0};
    level = {3'b0, h8 >= p1} + {3'b0, h8 >= p3} + {3'b0, h8 >= p5} + {3'b0, h8 >= p7};
  end
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state <= IDLE;
      s1 <= 1'b0;
      s <= 1'b0;
      prev <= 1'b0;
      pre <= '0;
      per_cnt <= '0;
      hi_cnt <= '0;
      o_period <= '0;
      o_high <= '0;
      o_level <= '0;
      o_valid <= 1'b0;
      o_stuck <= 1'b0;
    end else begin
      s1 <= i_pwm;
      s <= s1;
      prev <= s;
      pre <= tick ? '0 : pre + 1'b1;
      o_valid <= 1'b0;
      if (state != IDLE) begin
        per_cnt <= rise ? '0 : (tick && per_cnt != CNT_MAX) ? per_cnt + 1'b1 : per_cnt;
        hi_cnt <= rise ? '0 : (tick && s && hi_cnt != CNT_MAX) ? hi_cnt + 1'b1 : hi_cnt;
      end
      case (state)
        IDLE: if (rise) state <= MEASURE;
        MEASURE:
          if (rise) begin
            o_period <= per_cnt;
            o_high <= hi_cnt;
            o_level <= level;
            o_valid <= 1'b1;
          end else if (per_cnt >= TO) begin
            state <= STUCK;
            o_stuck <= 1'b1;
            o_level <= s ? 4'd4 : 4'd0;
          end
        default: begin
          o_level <= s ? 4'd4 : 4'd0;
          if (rise) begin
            state <= MEASURE;
            o_stuck <= 1'b0;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed PWM stimulus checked every cycle against a tick-total reference model
module tb_pwm_capture;
  localparam int DIV = 4;
  localparam int W = 10;
  localparam int TO = 1000;
  localparam int MAXC = 1023;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_pwm = 1'b0;
  logic [W-1:0] o_period, o_high;
  logic [3:0] o_level;
  logic o_valid, o_stuck;
  int total = 0;
  int bad = 0;
  int ecnt = 0;
  int vcnt = 0;
  int stuck_cnt = 0;
  int cap_p = 0, cap_h = 0, cap_l = 0;
  logic last_stuck = 1'b0;
  int m_mode, m_cyc, gt, gh, t0, h0;
  int e_period, e_high, e_level, e_valid, e_stuck;
  logic h1, h2, h3;

  pwm_capture #(.DIV(DIV), .CNT_W(W), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_reset(rst), .i_pwm(i_pwm),
    .o_period(o_period), .o_high(o_high), .o_level(o_level),
    .o_valid(o_valid), .o_stuck(o_stuck)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_cyc = 0; gt = 0; gh = 0; t0 = 0; h0 = 0;
    h1 = 0; h2 = 0; h3 = 0;
    e_period = 0; e_high = 0; e_level = 0; e_valid = 0; e_stuck = 0;
  endtask

  // expected outputs after the coming edge; periods are tick totals between rise cycles
  task automatic model_step();
    int sv, rs, tk, per, hi;
    sv = int'(h2);
    rs = int'(h2 && !h3);
    tk = int'((m_cyc % DIV) == DIV - 1);
    per = (gt - t0 > MAXC) ? MAXC : gt - t0;
    hi = (gh - h0 > MAXC) ? MAXC : gh - h0;
    e_valid = 0;
    if (m_mode == 0) begin
      if (rs != 0) m_mode = 1;
    end else if (m_mode == 1) begin
      if (rs != 0) begin
        e_period = per;
        e_high = hi;
        e_level = (per == 0) ? 4 : ((8 * hi + per) / (2 * per) > 4 ? 4 : (8 * hi + per) / (2 * per));
        e_valid = 1;
      end else if (per >= TO) begin
        m_mode = 2;
        e_stuck = 1;
        e_level = sv ? 4 : 0;
      end
    end else begin
      e_level = sv ? 4 : 0;
      if (rs != 0) begin
        m_mode = 1;
        e_stuck = 0;
      end
    end
    gt += tk;
    gh += tk & sv;
    if (rs != 0) begin
      t0 = gt;
      h0 = gh;
    end
    h3 = h2; h2 = h1; h1 = i_pwm; m_cyc++;
  endtask

  initial forever begin
    @(posedge clk);
    ecnt = rst ? 0 : ecnt + 1;
  end

  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (rst) model_reset();
      chk("period", int'(o_period), e_period);
      chk("high", int'(o_high), e_high);
      chk("level", int'(o_level), e_level);
      chk("valid", int'(o_valid), e_valid);
      chk("stuck", int'(o_stuck), e_stuck);
      if (o_valid) begin
        vcnt++;
        cap_p = int'(o_period);
        cap_h = int'(o_high);
        cap_l = int'(o_level);
      end
      if (o_stuck && !last_stuck) stuck_cnt++;
      last_stuck = o_stuck;
      if (!rst) model_step();
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic align();
    cyc(1);
    while (ecnt % DIV != 2) cyc(1);
  endtask

  task automatic pulse(input int hi_t, input int lo_t);
    i_pwm = 1'b1;
    cyc(hi_t * DIV);
    i_pwm = 1'b0;
    cyc(lo_t * DIV);
  endtask

  initial begin
    int hs[6] = '{1, 50, 150, 250, 350, 399};
    int ls[6] = '{0, 1, 2, 3, 4, 4};
    int v0, s0, e0, got;
    cyc(3);
    chk("rst_period", int'(o_period), 0);
    chk("rst_high", int'(o_high), 0);
    chk("rst_level", int'(o_level), 0);
    chk("rst_valid", int'(o_valid), 0);
    chk("rst_stuck", int'(o_stuck), 0);
    rst = 1'b0;
    align();
    // basic 50% duty
    pulse(200, 200);
    chk("first_rise_no_valid", vcnt, 0);
    pulse(200, 200);
    pulse(200, 200);
    chk("t1_valid_count", vcnt, 2);
    chk("t1_period", cap_p, 400);
    chk("t1_high", cap_h, 200);
    chk("t1_level", cap_l, 2);
    chk("t1_stuck", int'(o_stuck), 0);
    // duty sweep
    for (int i = 0; i < 6; i++) begin
      pulse(hs[i], 400 - hs[i]);
      if (i > 0) chk("sweep_level", cap_l, ls[i - 1]);
    end
    pulse(200, 200);
    chk("sweep_level_last", cap_l, ls[5]);
    chk("sweep_high_last", cap_h, 399);
    // static high line
    v0 = vcnt;
    i_pwm = 1'b1;
    cyc(998 * DIV);
    chk("t3_not_yet_stuck", int'(o_stuck), 0);
    cyc(4 * DIV);
    chk("t3_stuck", int'(o_stuck), 1);
    chk("t3_level_high", int'(o_level), 4);
    cyc(1200 * DIV - 1002 * DIV);
    i_pwm = 1'b0;
    cyc(100 * DIV);
    chk("t3_level_low", int'(o_level), 0);
    chk("t3_still_stuck", int'(o_stuck), 1);
    chk("t3_no_valid", vcnt, v0 + 1);
    pulse(200, 200);
    chk("t3_unstuck", int'(o_stuck), 0);
    chk("t3_exit_no_valid", vcnt, v0 + 1);
    pulse(200, 200);
    chk("t3_resume_valid", vcnt, v0 + 2);
    chk("t3_resume_period", cap_p, 400);
    // period longer than timeout
    v0 = vcnt;
    s0 = stuck_cnt;
    pulse(550, 550);
    pulse(550, 550);
    pulse(550, 550);
    chk("t4_valid_count", vcnt, v0 + 1);
    chk("t4_stuck_entries", stuck_cnt, s0 + 3);
    // reset mid-period
    pulse(200, 200);
    i_pwm = 1'b1;
    cyc(100 * DIV);
    #1;
    rst = 1'b1;
    i_pwm = 1'b0;
    #1;
    chk("t5_period", int'(o_period), 0);
    chk("t5_high", int'(o_high), 0);
    chk("t5_level", int'(o_level), 0);
    chk("t5_valid", int'(o_valid), 0);
    chk("t5_stuck", int'(o_stuck), 0);
    cyc(3);
    rst = 1'b0;
    align();
    v0 = vcnt;
    pulse(200, 200);
    chk("t5_first_no_valid", vcnt, v0);
    pulse(100, 300);
    chk("t5_second_no_valid", vcnt, v0 + 1);
    chk("t5_period_cap", cap_p, 400);
    chk("t5_high_cap", cap_h, 200);
    chk("t5_level_cap", cap_l, 2);
    // rise-to-valid latency
    i_pwm = 1'b1;
    e0 = ecnt;
    got = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (o_valid) begin
        got = 1;
        break;
      end
    end
    chk("t6_valid_seen", got, 1);
    chk("t6_latency", ecnt - e0, 3);
    @(negedge clk);
    chk("t6_valid_width", int'(o_valid), 0);
    chk("t6_level", int'(o_level), 1);
    cyc(10);
    i_pwm = 1'b0;
    cyc(10);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
endmodule
